// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Stage indices, control modes and readiness helpers for the pipeline hazard controller.
// Used by pipeline_hazard_ctrl and pipeline_hazard_ctrl_fwd_sel.
package pipeline_hazard_ctrl_pkg;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int FWD_RF = 0;

  typedef enum logic [1:0] {
    CTRL_NORMAL = 2'd0,
    CTRL_HAZARD = 2'd1,
    CTRL_BRANCH = 2'd2,
    CTRL_BUSY   = 2'd3
  } ctrl_mode_e;

  function automatic logic stage_ready(
    input int   stage,
    input logic is_load,
    input int   alu_rdy,
    input int   load_rdy
  );
    return is_load ? (stage >= load_rdy) : (stage >= alu_rdy);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Per-operand producer search: youngest-match hazard check and youngest-ready forward select.
// PIPE_FWD_EN undefined: o_fwd is tied to the register file and only WB counts as ready.
module pipeline_hazard_ctrl_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_W     = 5,
  parameter int ALU_RDY_STAGE  = 3,
  parameter int LOAD_RDY_STAGE = 4,
  parameter int FWD_W          = $clog2(NUM_STAGES)
) (
  input  logic [REG_ADDR_W-1:0]                    i_src,
  input  logic                                     i_use,
  input  logic [NUM_STAGES-1:STG_EX]               i_v,
  input  logic [NUM_STAGES-1:STG_EX]               i_rw,
  input  logic [NUM_STAGES-1:STG_EX]               i_mr,
  input  logic [NUM_STAGES-1:STG_EX][REG_ADDR_W-1:0] i_rd,
  output logic                                     o_hazard,
  output logic [FWD_W-1:0]                         o_fwd
);

`ifdef PIPE_FWD_EN
  localparam int ALU_RDY  = ALU_RDY_STAGE;
  localparam int LOAD_RDY = LOAD_RDY_STAGE;
`else
  // Without bypass paths a reader is satisfied only once the producer sits in WB.
  localparam int ALU_RDY  = max_int(ALU_RDY_STAGE, NUM_STAGES - 1);
  localparam int LOAD_RDY = max_int(LOAD_RDY_STAGE, NUM_STAGES - 1);
`endif

  logic [NUM_STAGES-1:STG_EX] w_match;
  logic [NUM_STAGES-1:STG_EX] w_rdy;
  logic                       w_found;

  genvar gi;
  generate
    for (gi = STG_EX; gi < NUM_STAGES; gi++) begin : g_stage
      assign w_match[gi] = i_use & i_v[gi] & i_rw[gi] &
                           (i_rd[gi] != '0) & (i_rd[gi] == i_src);
      assign w_rdy[gi]   = stage_ready(gi, i_mr[gi], ALU_RDY, LOAD_RDY);
    end
  endgenerate

  always_comb begin
    o_hazard = 1'b0;
    w_found  = 1'b0;
    for (int k = STG_EX; k < NUM_STAGES; k++) begin
      if (w_match[k] && !w_found) begin
        w_found  = 1'b1;
        o_hazard = ~w_rdy[k];
      end
    end
  end

`ifdef PIPE_FWD_EN
  logic w_fwd_found;

  always_comb begin
    o_fwd       = FWD_W'(FWD_RF);
    w_fwd_found = 1'b0;
    for (int k = STG_EX; k < NUM_STAGES; k++) begin
      if (w_match[k] && w_rdy[k] && !w_fwd_found) begin
        w_fwd_found = 1'b1;
        o_fwd       = FWD_W'(k);
      end
    end
  end
`else
  assign o_fwd = FWD_W'(FWD_RF);
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for an N-stage in-order pipeline with shadow stage records.
// Define PIPE_FWD_EN to enable EX operand forwarding; otherwise readers wait for WB.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_STAGE   = 3,
  parameter int ALU_RDY_STAGE  = 3,
  parameter int LOAD_RDY_STAGE = 4,
  parameter int FWD_W          = $clog2(NUM_STAGES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  output logic                  o_pc_en,
  output logic                  o_pc_sel,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [NUM_STAGES-1:0] o_stage_flush,
  output logic [FWD_W-1:0]      o_fwd_a,
  output logic [FWD_W-1:0]      o_fwd_b,
  output logic                  o_load_use_stall
);

  localparam logic [NUM_STAGES-1:0] BRANCH_FLUSH =
    {{(NUM_STAGES - BRANCH_STAGE){1'b0}}, {BRANCH_STAGE{1'b1}}};
  localparam logic [NUM_STAGES-1:0] STALL_EN    = ~(NUM_STAGES'(1) << STG_IF);
  localparam logic [NUM_STAGES-1:0] STALL_FLUSH = NUM_STAGES'(1) << STG_ID;

  // Record k describes the instruction currently in stage k; record 1 only needs a valid bit.
  logic [NUM_STAGES-1:STG_ID]                  r_v;
  logic [NUM_STAGES-1:STG_EX]                  r_rw;
  logic [NUM_STAGES-1:STG_EX]                  r_mr;
  logic [NUM_STAGES-1:STG_EX][REG_ADDR_W-1:0]  r_rd;

  logic [NUM_STAGES-1:STG_ID]                  w_src_v;
  logic [NUM_STAGES-1:STG_EX]                  w_src_rw;
  logic [NUM_STAGES-1:STG_EX]                  w_src_mr;
  logic [NUM_STAGES-1:STG_EX][REG_ADDR_W-1:0]  w_src_rd;

  logic                  w_hazard_a;
  logic                  w_hazard_b;
  logic                  w_hazard;
  logic                  w_branch;
  logic [FWD_W-1:0]      w_fwd_a;
  logic [FWD_W-1:0]      w_fwd_b;
  ctrl_mode_e            w_mode;
  logic                  w_pc_en;
  logic                  w_pc_sel;
  logic                  w_stall;
  logic [NUM_STAGES-1:0] w_stage_en;
  logic [NUM_STAGES-1:0] w_stage_flush;

  pipeline_hazard_ctrl_fwd_sel #(
    .NUM_STAGES     (NUM_STAGES),
    .REG_ADDR_W     (REG_ADDR_W),
    .ALU_RDY_STAGE  (ALU_RDY_STAGE),
    .LOAD_RDY_STAGE (LOAD_RDY_STAGE),
    .FWD_W          (FWD_W)
  ) u_fwd_rs1 (
    .i_src    (i_id_rs1),
    .i_use    (i_id_use_rs1),
    .i_v      (r_v[NUM_STAGES-1:STG_EX]),
    .i_rw     (r_rw),
    .i_mr     (r_mr),
    .i_rd     (r_rd),
    .o_hazard (w_hazard_a),
    .o_fwd    (w_fwd_a)
  );

  pipeline_hazard_ctrl_fwd_sel #(
    .NUM_STAGES     (NUM_STAGES),
    .REG_ADDR_W     (REG_ADDR_W),
    .ALU_RDY_STAGE  (ALU_RDY_STAGE),
    .LOAD_RDY_STAGE (LOAD_RDY_STAGE),
    .FWD_W          (FWD_W)
  ) u_fwd_rs2 (
    .i_src    (i_id_rs2),
    .i_use    (i_id_use_rs2),
    .i_v      (r_v[NUM_STAGES-1:STG_EX]),
    .i_rw     (r_rw),
    .i_mr     (r_mr),
    .i_rd     (r_rd),
    .o_hazard (w_hazard_b),
    .o_fwd    (w_fwd_b)
  );

  assign w_hazard = w_hazard_a | w_hazard_b;
  assign w_branch = i_branch_taken & r_v[BRANCH_STAGE];

  always_comb begin
    if (i_mem_busy) begin
      w_mode = CTRL_BUSY;
    end else if (w_branch) begin
      w_mode = CTRL_BRANCH;
    end else if (w_hazard) begin
      w_mode = CTRL_HAZARD;
    end else begin
      w_mode = CTRL_NORMAL;
    end
  end

  always_comb begin
    w_pc_en       = 1'b0;
    w_pc_sel      = 1'b0;
    w_stall       = 1'b0;
    w_stage_en    = '0;
    w_stage_flush = '0;
    unique case (w_mode)
      CTRL_BUSY: begin
        w_stage_en = '0;
      end
      CTRL_BRANCH: begin
        w_pc_en       = 1'b1;
        w_pc_sel      = 1'b1;
        w_stage_en    = '1;
        w_stage_flush = BRANCH_FLUSH;
      end
      CTRL_HAZARD: begin
        w_stage_en    = STALL_EN;
        w_stage_flush = STALL_FLUSH;
        w_stall       = 1'b1;
      end
      CTRL_NORMAL: begin
        w_pc_en    = 1'b1;
        w_stage_en = '1;
      end
    endcase
  end

  // Outputs follow the reset pin directly so they take safe values the moment reset asserts.
  assign o_pc_en          = i_rst_n & w_pc_en;
  assign o_pc_sel         = i_rst_n & w_pc_sel;
  assign o_load_use_stall = i_rst_n & w_stall;
  assign o_stage_en       = i_rst_n ? w_stage_en : '0;
  assign o_stage_flush    = i_rst_n ? w_stage_flush : '1;
  assign o_fwd_a          = i_rst_n ? w_fwd_a : FWD_W'(FWD_RF);
  assign o_fwd_b          = i_rst_n ? w_fwd_b : FWD_W'(FWD_RF);

  assign w_src_v[STG_ID] = 1'b1;

  genvar gi;
  generate
    for (gi = STG_EX; gi < NUM_STAGES; gi++) begin : g_src
      if (gi == STG_EX) begin : g_from_id
        assign w_src_v[gi]  = r_v[STG_ID];
        assign w_src_rd[gi] = i_id_rd;
        assign w_src_rw[gi] = i_id_reg_write;
        assign w_src_mr[gi] = i_id_mem_read;
      end else begin : g_from_rec
        assign w_src_v[gi]  = r_v[gi-1];
        assign w_src_rd[gi] = r_rd[gi-1];
        assign w_src_rw[gi] = r_rw[gi-1];
        assign w_src_mr[gi] = r_mr[gi-1];
      end
    end
  endgenerate

  // Record k mirrors the pipeline register after stage k-1: same enable, same bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v  <= '0;
      r_rw <= '0;
      r_mr <= '0;
      r_rd <= '0;
    end else begin
      for (int k = STG_ID; k < NUM_STAGES; k++) begin
        if (w_stage_en[k-1]) begin
          r_v[k] <= w_src_v[k] & ~w_stage_flush[k-1];
        end
      end
      for (int k = STG_EX; k < NUM_STAGES; k++) begin
        if (w_stage_en[k-1]) begin
          r_rd[k] <= w_stage_flush[k-1] ? '0 : w_src_rd[k];
          r_rw[k] <= w_src_rw[k] & ~w_stage_flush[k-1];
          r_mr[k] <= w_src_mr[k] & ~w_stage_flush[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl against an instruction-list model.
// Follows PIPE_FWD_EN the same way as the design build.
module tb_pipeline_hazard_ctrl;

  localparam int N  = 5;
  localparam int W  = 5;
  localparam int FW = 3;
  localparam int BR = 3;
  localparam int M_NORMAL = 0;
  localparam int M_HAZARD = 1;
  localparam int M_BRANCH = 2;
  localparam int M_BUSY   = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic         use1 = 1'b0, use2 = 1'b0, rw = 1'b0, mr = 1'b0;
  logic         branch = 1'b0, busy = 1'b0;

  logic          pc_en, pc_sel, stall;
  logic [N-1:0]  stage_en, stage_flush;
  logic [FW-1:0] fwd_a, fwd_b;

  pipeline_hazard_ctrl #(
    .NUM_STAGES(N), .REG_ADDR_W(W), .BRANCH_STAGE(BR),
    .ALU_RDY_STAGE(3), .LOAD_RDY_STAGE(4), .FWD_W(FW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_rd(rd), .i_id_reg_write(rw), .i_id_mem_read(mr),
    .i_branch_taken(branch), .i_mem_busy(busy),
    .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_stage_en(stage_en), .o_stage_flush(stage_flush),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_load_use_stall(stall)
  );

  always #5 clk = ~clk;

  // Model: list of valid in-flight instructions (stage >= EX), youngest first, plus ID validity.
  typedef struct {
    int           stage;
    logic [W-1:0] rd;
    logic         rw;
    logic         mr;
  } instr_t;

  instr_t inflight[$];
  bit     id_valid;
  int     m_mode;
  int     n_tests = 0;
  int     n_fail  = 0;

  logic          e_pc_en, e_pc_sel, e_stall;
  logic [N-1:0]  e_stage_en, e_stage_flush;
  logic [FW-1:0] e_fwd_a, e_fwd_b;

  function automatic int ready_stage(input logic is_load);
`ifdef PIPE_FWD_EN
    return is_load ? 4 : 3;
`else
    return N - 1;
`endif
  endfunction

  function automatic void lookup(input logic [W-1:0] src, input logic use_it,
                                 output bit haz, output int fwd);
    bit seen;
    bit ready;
    seen = 0;
    haz  = 0;
    fwd  = 0;
    foreach (inflight[i]) begin
      if (use_it && inflight[i].rw && inflight[i].rd != 0 && inflight[i].rd == src) begin
        ready = (inflight[i].stage >= ready_stage(inflight[i].mr));
        if (!seen) begin
          seen = 1;
          haz  = !ready;
        end
`ifdef PIPE_FWD_EN
        if (ready && fwd == 0) fwd = inflight[i].stage;
`endif
      end
    end
  endfunction

  task automatic model_reset();
    inflight.delete();
    id_valid = 0;
  endtask

  task automatic predict();
    bit ha, hb, br_ok;
    int fa, fb;
    if (!rst_n) begin
      e_pc_en = 0; e_pc_sel = 0; e_stall = 0;
      e_stage_en = '0; e_stage_flush = '1;
      e_fwd_a = '0; e_fwd_b = '0;
      m_mode = M_BUSY;
      return;
    end
    lookup(rs1, use1, ha, fa);
    lookup(rs2, use2, hb, fb);
    br_ok = 0;
    foreach (inflight[i]) if (inflight[i].stage == BR) br_ok = 1;
    if (busy) m_mode = M_BUSY;
    else if (branch && br_ok) m_mode = M_BRANCH;
    else if (ha || hb) m_mode = M_HAZARD;
    else m_mode = M_NORMAL;
    e_fwd_a = FW'(fa);
    e_fwd_b = FW'(fb);
    case (m_mode)
      M_BUSY:   begin e_pc_en = 0; e_pc_sel = 0; e_stall = 0; e_stage_en = 5'b00000; e_stage_flush = 5'b00000; end
      M_BRANCH: begin e_pc_en = 1; e_pc_sel = 1; e_stall = 0; e_stage_en = 5'b11111; e_stage_flush = 5'b00111; end
      M_HAZARD: begin e_pc_en = 0; e_pc_sel = 0; e_stall = 1; e_stage_en = 5'b11110; e_stage_flush = 5'b00010; end
      default:  begin e_pc_en = 1; e_pc_sel = 0; e_stall = 0; e_stage_en = 5'b11111; e_stage_flush = 5'b00000; end
    endcase
  endtask

  task automatic advance();
    instr_t nq[$];
    instr_t t;
    if (m_mode == M_BUSY) return;
    foreach (inflight[i]) begin
      t = inflight[i];
      t.stage++;
      if (t.stage < N && !(m_mode == M_BRANCH && t.stage <= BR)) nq.push_back(t);
    end
    if (m_mode == M_NORMAL) begin
      if (id_valid) begin
        t.stage = 2; t.rd = rd; t.rw = rw; t.mr = mr;
        nq.push_front(t);
      end
      id_valid = 1;
    end else if (m_mode == M_BRANCH) begin
      id_valid = 0;
    end
    inflight = nq;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_en"},  32'(pc_en),       32'(e_pc_en));
    check({tag, ".pc_sel"}, 32'(pc_sel),      32'(e_pc_sel));
    check({tag, ".stall"},  32'(stall),       32'(e_stall));
    check({tag, ".en"},     32'(stage_en),    32'(e_stage_en));
    check({tag, ".flush"},  32'(stage_flush), 32'(e_stage_flush));
    check({tag, ".fwd_a"},  32'(fwd_a),       32'(e_fwd_a));
    check({tag, ".fwd_b"},  32'(fwd_b),       32'(e_fwd_b));
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    if (!rst_n) model_reset();
    predict();
    check_all(tag);
    @(posedge clk);
    if (rst_n) advance();
    #1;
  endtask

  task automatic set_id(input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit w, input bit ld);
    rs1 = W'(s1); use1 = u1; rs2 = W'(s2); use2 = u2;
    rd = W'(d); rw = w; mr = ld;
  endtask

  initial begin
    model_reset();
    #2;
    step("reset0");
    step("reset1");
    rst_n = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    step("nop");
    // add x1 then a reader of x1
    set_id(0, 0, 0, 0, 1, 1, 0);
    step("add_x1");
    set_id(1, 1, 0, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) step("use_x1");
    // lw x5 then a reader of x5 on rs2
    set_id(0, 0, 0, 0, 5, 1, 1);
    step("lw_x5");
    set_id(0, 0, 5, 1, 7, 1, 0);
    for (int i = 0; i < 4; i++) step("use_x5");
    // branch with a valid instruction in the branch stage
    set_id(2, 1, 3, 1, 3, 1, 0);
    step("pre_br");
    branch = 1'b1;
    step("branch");
    branch = 1'b0;
    step("post_br");
    // memory stall in the middle of a load-use stall
    set_id(0, 0, 0, 0, 6, 1, 1);
    step("lw_x6");
    set_id(6, 1, 0, 0, 8, 1, 0);
    step("use_x6");
    busy = 1'b1;
    for (int i = 0; i < 3; i++) step("busy");
    busy = 1'b0;
    for (int i = 0; i < 3; i++) step("resume");
    // x0 producer never creates a dependency
    set_id(0, 0, 0, 0, 0, 1, 1);
    step("wr_x0");
    set_id(0, 1, 0, 1, 9, 1, 0);
    step("rd_x0");
    // asynchronous reset in the middle of a stall
    set_id(0, 0, 0, 0, 4, 1, 1);
    step("lw_x4");
    set_id(4, 1, 0, 0, 10, 1, 0);
    step("use_x4");
    rst_n = 1'b0;
    #1;
    model_reset();
    predict();
    check_all("rst_async");
    step("rst_hold");
    rst_n = 1'b1;
    step("rst_rel");
    // randomised traffic on a small register set to provoke frequent dependencies
    for (int c = 0; c < 500; c++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0);
      busy   = ($urandom_range(0, 9) == 0);
      branch = ($urandom_range(0, 7) == 0);
      step("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
